// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the byte-serial RV32I instruction fetcher.
// Used by inst_fetcher and fetch_word_assembler.
package inst_fetcher_pkg;

  localparam int          INST_W           = 32;
  localparam int          BYTES_PER_INST   = 4;
  localparam int          BYTE_IDX_W       = 2;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  function automatic logic lastByte(input logic [BYTE_IDX_W-1:0] idx);
    return idx == BYTE_IDX_W'(BYTES_PER_INST - 1);
  endfunction

endpackage

// File: rtl/fetch_word_assembler.sv
// Byte counter and little-endian lane capture for one instruction word.
// A byte whose address is granted is captured one enabled cycle later.
module fetch_word_assembler
  import inst_fetcher_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  flush_i,
  input  logic                  issue_i,
  input  logic [7:0]            byte_i,
  output logic [BYTE_IDX_W-1:0] byteIdx_o,
  output logic                  wordDone_o,
  output logic [INST_W-1:0]     word_o
);

  logic [BYTE_IDX_W-1:0] byteIdx_q, byteIdx_d;
  logic [BYTE_IDX_W-1:0] lane_q, lane_d;
  logic                  pending_q, pending_d;
  logic [INST_W-9:0]     low_q, low_d;

  // The top byte is never stored: it is forwarded straight from the memory
  // bus in the same cycle the word completes.
  always_comb begin
    byteIdx_d = byteIdx_q;
    lane_d    = lane_q;
    pending_d = pending_q;
    low_d     = low_q;
    if (flush_i) begin
      byteIdx_d = '0;
      pending_d = 1'b0;
    end else begin
      if (pending_q && !lastByte(lane_q)) begin
        low_d[{lane_q, 3'b000} +: 8] = byte_i;
      end
      pending_d = issue_i;
      if (issue_i) begin
        lane_d    = byteIdx_q;
        byteIdx_d = byteIdx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byteIdx_q <= '0;
      lane_q    <= '0;
      pending_q <= 1'b0;
      low_q     <= '0;
    end else if (en_i) begin
      byteIdx_q <= byteIdx_d;
      lane_q    <= lane_d;
      pending_q <= pending_d;
      low_q     <= low_d;
    end
  end

  assign byteIdx_o  = byteIdx_q;
  assign wordDone_o = en_i && !flush_i && pending_q && lastByte(lane_q);
  assign word_o     = {byte_i, low_q};

endmodule

// File: rtl/inst_fetcher.sv
// Fetches RV32I words over a byte-wide memory port and hands them to decode.
// Optional IFETCH_SKID_EN adds a one-entry skid so fetching continues under stall.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_din,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [INST_W-1:0]     inst_q, inst_d;
  logic [ADDR_W-1:0]     instPc_q, instPc_d;
  logic                  instValid_q, instValid_d;
`ifdef IFETCH_SKID_EN
  logic                  skidValid_q, skidValid_d;
  logic [INST_W-1:0]     skidWord_q, skidWord_d;
  logic [ADDR_W-1:0]     skidPc_q, skidPc_d;
`endif

  logic [BYTE_IDX_W-1:0] byteIdx;
  logic                  wordDone;
  logic [INST_W-1:0]     word;
  logic                  memIssue;
  logic                  handshake;

  assign memIssue  = (state_q == ST_FETCH) && mem_gnt;
  assign handshake = instValid_q && inst_ready;

  fetch_word_assembler u_assembler (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .en_i       (rdy_in),
    .flush_i    (redirect_valid),
    .issue_i    (memIssue),
    .byte_i     (mem_din),
    .byteIdx_o  (byteIdx),
    .wordDone_o (wordDone),
    .word_o     (word)
  );

  // pc advances when a word completes; observably identical to advancing on
  // handshake since no address is issued from HOLD without the skid.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    instPc_d    = instPc_q;
    instValid_d = instValid_q;
`ifdef IFETCH_SKID_EN
    skidValid_d = skidValid_q;
    skidWord_d  = skidWord_q;
    skidPc_d    = skidPc_q;
`endif
    if (handshake) instValid_d = 1'b0;

    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (memIssue && lastByte(byteIdx)) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (wordDone) begin
          pc_d = pc_q + ADDR_W'(BYTES_PER_INST);
`ifdef IFETCH_SKID_EN
          if (instValid_q && !inst_ready) begin
            skidValid_d = 1'b1;
            skidWord_d  = word;
            skidPc_d    = pc_q;
            state_d     = ST_HOLD;
          end else begin
            inst_d      = word;
            instPc_d    = pc_q;
            instValid_d = 1'b1;
            state_d     = ST_FETCH;
          end
`else
          inst_d      = word;
          instPc_d    = pc_q;
          instValid_d = 1'b1;
          state_d     = ST_HOLD;
`endif
        end
      end
      ST_HOLD: begin
        if (handshake) begin
`ifdef IFETCH_SKID_EN
          inst_d      = skidWord_q;
          instPc_d    = skidPc_q;
          instValid_d = skidValid_q;
          skidValid_d = 1'b0;
`endif
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Redirect beats everything, including a same-cycle handshake.
    if (redirect_valid) begin
      state_d     = ST_FETCH;
      pc_d        = redirect_pc & ~ADDR_W'(3);
      instValid_d = 1'b0;
`ifdef IFETCH_SKID_EN
      skidValid_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      pc_q        <= ADDR_W'(RESET_PC);
      inst_q      <= '0;
      instPc_q    <= '0;
      instValid_q <= 1'b0;
`ifdef IFETCH_SKID_EN
      skidValid_q <= 1'b0;
      skidWord_q  <= '0;
      skidPc_q    <= '0;
`endif
    end else if (rdy_in) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      instPc_q    <= instPc_d;
      instValid_q <= instValid_d;
`ifdef IFETCH_SKID_EN
      skidValid_q <= skidValid_d;
      skidWord_q  <= skidWord_d;
      skidPc_q    <= skidPc_d;
`endif
    end
  end

  assign mem_req    = (state_q == ST_FETCH);
  assign mem_addr   = mem_req ? (pc_q + ADDR_W'(byteIdx)) : '0;
  assign inst_valid = instValid_q;
  assign inst       = inst_q;
  assign inst_pc    = instPc_q;

endmodule
